image_frame_capture: RTL and testbench

- Hardware counterpart of the bench-side output dump for image_blur. It waits for image_blur's done, then samples the serial R,G,B byte stream on image_out for one full frame.
- Packs each byte triplet into a 24-bit pixel and issues one write per pixel to a frame-buffer memory port.
- Sits between image_blur and the output frame buffer, replacing the bench's file write in synthesizable designs.

---
 rtl/image_frame_capture.sv | 132 +++++++++++++
 tb/tb_image_frame_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_capture.sv
// Captures one frame of serial R,G,B bytes from image_blur after its done
// indication and writes each packed 24-bit pixel to a frame-buffer port.
module image_frame_capture #(
    parameter int WIDTH  = 350,
    parameter int HEIGHT = 350,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    input  logic [7:0]        image_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int PIXELS = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [1:0]        phase_reg, phase_next;
    logic [ADDR_W-1:0] pix_reg, pix_next;
    logic [7:0]        r_reg, r_next;
    logic [7:0]        g_reg, g_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
    logic [23:0]       wr_data_reg, wr_data_next;
    logic              busy_reg, busy_next;
    logic              frame_done_reg, frame_done_next;

    always_comb begin
        state_next      = state_reg;
        phase_next      = phase_reg;
        pix_next        = pix_reg;
        r_next          = r_reg;
        g_next          = g_reg;
        wr_en_next      = 1'b0;
        wr_addr_next    = wr_addr_reg;
        wr_data_next    = wr_data_reg;
        busy_next       = busy_reg;
        frame_done_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (done) begin
                    state_next = SKIP;
                    busy_next  = 1'b1;
                end
            end
            // One-cycle alignment gap: image_in is not yet valid here.
            SKIP: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                case (phase_reg)
                    2'd0: begin
                        r_next     = image_in;
                        phase_next = 2'd1;
                    end
                    2'd1: begin
                        g_next     = image_in;
                        phase_next = 2'd2;
                    end
                    default: begin
                        wr_en_next   = 1'b1;
                        wr_data_next = {r_reg, g_reg, image_in};
                        wr_addr_next = pix_reg;
                        phase_next   = 2'd0;
                        if (pix_reg == LAST_PIX) begin
                            state_next = FINISH;
                            pix_next   = '0;
                        end else begin
                            pix_next = pix_reg + 1'b1;
                        end
                    end
                endcase
            end
            FINISH: begin
                frame_done_next = 1'b1;
                busy_next       = 1'b0;
                phase_next      = 2'd0;
                pix_next        = '0;
                state_next      = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            phase_reg      <= 2'd0;
            pix_reg        <= '0;
            r_reg          <= 8'd0;
            g_reg          <= 8'd0;
            wr_en_reg      <= 1'b0;
            wr_addr_reg    <= '0;
            wr_data_reg    <= 24'd0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            phase_reg      <= phase_next;
            pix_reg        <= pix_next;
            r_reg          <= r_next;
            g_reg          <= g_next;
            wr_en_reg      <= wr_en_next;
            wr_addr_reg    <= wr_addr_next;
            wr_data_reg    <= wr_data_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign wr_en      = wr_en_reg;
    assign wr_addr    = wr_addr_reg;
    assign wr_data    = wr_data_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_image_frame_capture.sv
// Scoreboard bench for image_frame_capture on a 4x2 frame: stimulus pushes
// expected writes and frame_done cycles, a negedge monitor pops and compares.
module tb_image_frame_capture;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int ADDR_W = 3;
    localparam int PIXELS = WIDTH * HEIGHT;

    logic              clk = 1'b0;
    logic              reset;
    logic              done;
    logic [7:0]        image_in;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic              busy;
    logic              frame_done;

    image_frame_capture #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .done      (done),
        .image_in  (image_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
    } wr_t;

    wr_t wr_q[$];
    int  fd_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: cyc equals the index of the edge that produced these outputs.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=0x%06h at cycle %0d, none expected",
                         wr_addr, wr_data, cyc);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("write_cycle", cyc, e.cyc);
                chk("write_addr", 32'(wr_addr), 32'(e.addr));
                chk("write_data", 32'(wr_data), 32'(e.data));
                $display("write addr=%0d data=0x%06h cycle=%0d", wr_addr, wr_data, cyc);
            end
        end
        if (frame_done === 1'b1) begin
            if (fd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame_done: at cycle %0d, none expected", cyc);
            end else begin
                chk("frame_done_cycle", cyc, fd_q.pop_front());
                $display("frame_done cycle=%0d", cyc);
            end
        end
    end

    // Called #1 after edge n (the edge that sampled done). Byte k of the frame
    // is base+k; the SKIP-cycle byte is 0xFF. abort_edge != 0 asserts reset
    // so that it is sampled at that edge.
    task automatic feed_frame(input int n, input logic [7:0] base, input int abort_edge);
        for (int p = 0; p < PIXELS; p++) begin
            wr_t e;
            logic [7:0] b0, b1, b2;
            b0 = base + 8'(3 * p);
            b1 = b0 + 8'd1;
            b2 = b0 + 8'd2;
            e.cyc  = n + 4 + 3 * p;
            e.addr = ADDR_W'(p);
            e.data = {b0, b1, b2};
            if (abort_edge == 0 || e.cyc < abort_edge) wr_q.push_back(e);
        end
        if (abort_edge == 0) fd_q.push_back(n + 2 + 3 * PIXELS);

        image_in = 8'hFF;
        for (int k = 0; k < 3 * PIXELS; k++) begin
            @(posedge clk); #1;
            if (abort_edge != 0 && cyc + 1 == abort_edge) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                image_in = 8'h00;
                return;
            end
            image_in = base + 8'(k);
        end
        @(posedge clk); #1;
        image_in = 8'h00;
    endtask

    // Raises done so it is sampled at the next edge; returns #1 after it.
    task automatic start_frame(output int n);
        @(posedge clk); #1;
        done = 1'b1;
        n = cyc + 1;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        reset    = 1'b1;
        done     = 1'b0;
        image_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_wr_en", 32'(wr_en), 0);
        chk("reset_wr_addr", 32'(wr_addr), 0);
        chk("reset_wr_data", 32'(wr_data), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_frame_done", 32'(frame_done), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);

        // Frame A: single done pulse, bytes 0x00..0x17.
        start_frame(n);
        done = 1'b0;
        chk("a_busy_start", 32'(busy), 1);
        feed_frame(n, 8'h00, 0);
        @(posedge clk); #1;
        chk("a_busy_end", 32'(busy), 0);
        chk("a_addr_hold", 32'(wr_addr), PIXELS - 1);
        repeat (4) @(posedge clk);
        #1;
        chk("a_addr_hold_idle", 32'(wr_addr), PIXELS - 1);

        // Frame B: done held across the frame; a second capture follows at n+27.
        start_frame(n);
        chk("b_busy_start", 32'(busy), 1);
        feed_frame(n, 8'h40, 0);
        @(posedge clk); #1;
        chk("b_busy_at_frame_done", 32'(busy), 0);
        @(posedge clk); #1;
        chk("b2_restart_cycle", cyc, n + 3 + 3 * PIXELS);
        chk("b2_busy_restart", 32'(busy), 1);
        done = 1'b0;
        feed_frame(cyc, 8'h80, 0);
        @(posedge clk); #1;
        chk("b2_busy_end", 32'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("b2_no_third_capture", 32'(busy), 0);

        // Frame C: reset sampled at edge n+10 abandons the frame.
        start_frame(n);
        done = 1'b0;
        feed_frame(n, 8'h20, n + 10);
        chk("c_busy_after_reset", 32'(busy), 0);
        chk("c_wr_en_after_reset", 32'(wr_en), 0);
        repeat (30) @(posedge clk);
        #1;
        chk("c_busy_idle", 32'(busy), 0);

        // Frame D: fresh capture after the abort starts again at address 0.
        start_frame(n);
        done = 1'b0;
        feed_frame(n, 8'hC0, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("d_busy_end", 32'(busy), 0);

        chk("pending_writes", wr_q.size(), 0);
        chk("pending_frame_done", fd_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
